// File: rtl/mcycle_pkg.sv
// Shared constants for the multi-cycle multiply/divide unit.
// Op encoding, FSM state encoding and operand signedness helpers.
package mcycle_pkg;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_COMP = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   function automatic logic is_div_op(input logic [2:0] op);
      return op[2];
   endfunction

   function automatic logic is_signed_op1(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
             (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic is_signed_op2(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_MULH) ||
             (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/mcycle_radix_unit_if.sv
// Request/response bundle between the EX stage and the mul/div unit.
// master drives requests, slave is the unit itself.
interface mcycle_radix_unit_if #(
   parameter int WIDTH = 32
);
   logic             Start;
   logic             Abort;
   logic [2:0]       MCycleOp;
   logic [WIDTH-1:0] Operand1;
   logic [WIDTH-1:0] Operand2;
   logic [WIDTH-1:0] Result1;
   logic [WIDTH-1:0] Result2;
   logic [WIDTH-1:0] Result;
   logic             Busy;
   logic             Done;

   modport master (
      output Start, Abort, MCycleOp, Operand1, Operand2,
      input  Result1, Result2, Result, Busy, Done
   );

   modport slave (
      input  Start, Abort, MCycleOp, Operand1, Operand2,
      output Result1, Result2, Result, Busy, Done
   );
endinterface

// File: rtl/mcycle_div_slice.sv
// Combinational DIV_BPC-step restoring divider slice, MSB first.
// quo_i carries the remaining dividend bits, shifted out as quotient bits enter.
module mcycle_div_slice #(
   parameter int WIDTH   = 32,
   parameter int DIV_BPC = 8
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] div_i,
   input  logic [WIDTH-1:0] quo_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);
   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] q;
   logic [WIDTH:0]   t;

   always_comb begin
      r = rem_i;
      q = quo_i;
      t = '0;
      for (int i = 0; i < DIV_BPC; i++) begin
         t = {r, q[WIDTH-1]};
         q = {q[WIDTH-2:0], 1'b0};
         if (t >= {1'b0, div_i}) begin
            t    = t - {1'b0, div_i};
            q[0] = 1'b1;
         end
         r = t[WIDTH-1:0];
      end
      rem_o = r;
      quo_o = q;
   end
endmodule

// File: rtl/mcycle_radix_unit.sv
// Multi-cycle RV32M multiply/divide unit for the EX stage.
// Works on operand magnitudes, then applies signs and corner cases in FIXUP.
module mcycle_radix_unit
   import mcycle_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int MUL_BPC = 8,
   parameter int DIV_BPC = 8
) (
   input  logic CLK,
   input  logic RESETn,
   mcycle_radix_unit_if.slave bus
);
   localparam int MUL_N = WIDTH / MUL_BPC;
   localparam int DIV_N = WIDTH / DIV_BPC;
   localparam int CW    = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] MUL_LAST = CW'(MUL_N - 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(DIV_N - 1);
   localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ONE_V = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]         state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               sa_q, sa_d;
   logic               sb_q, sb_d;
   logic               dz_q, dz_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   res1_q, res1_d;
   logic [WIDTH-1:0]   res2_q, res2_d;
   logic [WIDTH-1:0]   res_q, res_d;

   logic               s1, s2, start_ok, in_div;
   logic [WIDTH-1:0]   mag1, mag2;
   logic [31:0]        sh;
   logic [MUL_BPC-1:0] bsl;
   logic [2*WIDTH-1:0] pp;
   logic [WIDTH-1:0]   dv_rem, dv_quo;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   fix1, fix2, fixr;
   logic               ovf;

   mcycle_div_slice #(
      .WIDTH   (WIDTH),
      .DIV_BPC (DIV_BPC)
   ) u_div (
      .rem_i (acc_q[2*WIDTH-1:WIDTH]),
      .div_i (b_q),
      .quo_i (acc_q[WIDTH-1:0]),
      .rem_o (dv_rem),
      .quo_o (dv_quo)
   );

   always_comb begin
      s1       = is_signed_op1(bus.MCycleOp) & bus.Operand1[WIDTH-1];
      s2       = is_signed_op2(bus.MCycleOp) & bus.Operand2[WIDTH-1];
      mag1     = s1 ? -bus.Operand1 : bus.Operand1;
      mag2     = s2 ? -bus.Operand2 : bus.Operand2;
      in_div   = is_div_op(bus.MCycleOp);
      start_ok = bus.Start & ~bus.Abort;
      sh       = 32'(cnt_q) * 32'(MUL_BPC);
      bsl      = MUL_BPC'(b_q >> sh);
      pp       = {{WIDTH{1'b0}}, a_q} *
                 {{(2*WIDTH-MUL_BPC){1'b0}}, bsl};
   end

   // Signs are folded back in here; divide corner cases override.
   always_comb begin
      prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
      ovf  = sa_q & sb_q & (a_q == MIN_V) & (b_q == ONE_V);
      if (op_q[2]) begin
         fix1 = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
         fix2 = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
         if (dz_q) begin
            fix1 = '1;
            fix2 = sa_q ? -a_q : a_q;
         end else if (ovf) begin
            fix1 = MIN_V;
            fix2 = '0;
         end
      end else begin
         fix1 = prod[WIDTH-1:0];
         fix2 = prod[2*WIDTH-1:WIDTH];
      end
      fixr = ((op_q == OP_MUL) || (op_q == OP_DIV) || (op_q == OP_DIVU))
             ? fix1 : fix2;
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      dz_d    = dz_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      res1_d  = res1_q;
      res2_d  = res2_q;
      res_d   = res_q;
      case (state_q)
         S_IDLE: begin
            if (start_ok) begin
               op_d    = bus.MCycleOp;
               sa_d    = s1;
               sb_d    = s2;
               a_d     = mag1;
               b_d     = mag2;
               cnt_d   = '0;
               dz_d    = in_div & (bus.Operand2 == '0);
               acc_d   = in_div ? {{WIDTH{1'b0}}, mag1} : '0;
               state_d = (in_div & (bus.Operand2 == '0)) ? S_FIX : S_COMP;
            end
         end
         S_COMP: begin
            cnt_d = cnt_q + 1'b1;
            if (op_q[2]) begin
               acc_d = {dv_rem, dv_quo};
               if (cnt_q == DIV_LAST) state_d = S_FIX;
            end else begin
               acc_d = acc_q + (pp << sh);
               if (cnt_q == MUL_LAST) state_d = S_FIX;
            end
         end
         S_FIX: begin
            res1_d  = fix1;
            res2_d  = fix2;
            res_d   = fixr;
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
      if (bus.Abort) begin
         state_d = S_IDLE;
         res1_d  = res1_q;
         res2_d  = res2_q;
         res_d   = res_q;
      end
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         cnt_q   <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         dz_q    <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         res1_q  <= '0;
         res2_q  <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         dz_q    <= dz_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         res1_q  <= res1_d;
         res2_q  <= res2_d;
         res_q   <= res_d;
      end
   end

   assign bus.Result1 = res1_q;
   assign bus.Result2 = res2_q;
   assign bus.Result  = res_q;
   assign bus.Done    = (state_q == S_DONE);
   assign bus.Busy    = RESETn & ~bus.Abort &
                        (((state_q == S_IDLE) & bus.Start) |
                         (state_q == S_COMP) | (state_q == S_FIX));
endmodule

// File: tb/tb_mcycle_radix_unit.sv
// Self-checking bench for mcycle_radix_unit (WIDTH=32, 8 bits per cycle).
// Fixed vectors, hand sequences for abort/reset/held-start, random sweep vs. arithmetic model.
module tb_mcycle_radix_unit;

   logic CLK;
   logic RESETn;
   int   checks;
   int   failures;

   mcycle_radix_unit_if #(.WIDTH(32)) bus ();

   mcycle_radix_unit #(
      .WIDTH   (32),
      .MUL_BPC (8),
      .DIV_BPC (8)
   ) dut (
      .CLK    (CLK),
      .RESETn (RESETn),
      .bus    (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [31:0] r;
      int          lat;
      string       nm;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Plain-arithmetic reference: 64-bit product / truncating division.
   function automatic void model(input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r1,
                                 output logic [31:0] r2,
                                 output logic [31:0] r,
                                 output int lat);
      longint sa, sb, p, q, rm;
      bit s1, s2;
      s1 = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) ||
           (op == 3'd4) || (op == 3'd6);
      s2 = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
      sa = s1 ? {{32{a[31]}}, a} : {32'b0, a};
      sb = s2 ? {{32{b[31]}}, b} : {32'b0, b};
      lat = 6;
      if (!op[2]) begin
         p  = sa * sb;
         r1 = p[31:0];
         r2 = p[63:32];
      end else if (b == 32'd0) begin
         r1  = 32'hFFFF_FFFF;
         r2  = a;
         lat = 2;
      end else if (s1 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         r1 = 32'h8000_0000;
         r2 = 32'd0;
      end else begin
         q  = sa / sb;
         rm = sa % sb;
         r1 = q[31:0];
         r2 = rm[31:0];
      end
      r = (op == 3'd0 || op == 3'd4 || op == 3'd5) ? r1 : r2;
   endfunction

   // Called at a negedge with the unit idle; returns at the negedge after Done.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input string nm,
                         output logic [31:0] r1, output logic [31:0] r2,
                         output logic [31:0] r, output int lat);
      bus.MCycleOp = op;
      bus.Operand1 = a;
      bus.Operand2 = b;
      bus.Start    = 1'b1;
      #1;
      chk({nm, ":busy_start"}, {31'b0, bus.Busy}, 32'd1);
      @(posedge CLK);
      #1;
      bus.Start    = 1'b0;
      bus.MCycleOp = 3'($urandom);
      bus.Operand1 = $urandom;
      bus.Operand2 = $urandom;
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge CLK);
         if (bus.Done) begin
            lat = c;
            break;
         end
      end
      r1 = bus.Result1;
      r2 = bus.Result2;
      r  = bus.Result;
      chk({nm, ":busy_done"}, {31'b0, bus.Busy}, 32'd0);
      @(negedge CLK);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(0, 300));
         5:       return -32'($urandom_range(1, 300));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] r1, r2, r, e1, e2, er, p1, p2;
      int lat, elat;
      logic [2:0] op;
      logic [31:0] a, b;

      checks   = 0;
      failures = 0;
      tbl[0]  = '{3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32'hFFFF_FFFF,
                  32'hFFFF_FFEB, 6, "mul_7_m3"};
      tbl[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001,
                  32'hFFFF_FFFE, 32'hFFFF_FFFE, 6, "mulhu_max"};
      tbl[2]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001,
                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 6, "mulhsu_m1"};
      tbl[3]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001,
                  32'h0, 32'h0, 6, "mulh_m1"};
      tbl[4]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h0,
                  32'h4000_0000, 32'h0, 6, "mul_min"};
      tbl[5]  = '{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                  32'hFFFF_FFFD, 6, "div_m7_2"};
      tbl[6]  = '{3'd7, 32'd100, 32'd7, 32'd14, 32'd2, 32'd2, 6, "remu_100_7"};
      tbl[7]  = '{3'd5, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0,
                  32'hFFFF_FFFF, 6, "divu_max_1"};
      tbl[8]  = '{3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5,
                  32'hFFFF_FFFF, 2, "divu_by0"};
      tbl[9]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,
                  32'h8000_0000, 6, "div_ovf"};
      tbl[10] = '{3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                  32'hFFFF_FFF9, 2, "rem_by0"};
      tbl[11] = '{3'd6, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,
                  32'd1, 6, "rem_7_m2"};

      RESETn       = 1'b1;
      bus.Start    = 1'b0;
      bus.Abort    = 1'b0;
      bus.MCycleOp = 3'd0;
      bus.Operand1 = '0;
      bus.Operand2 = '0;
      #2 RESETn = 1'b0;
      #1;
      chk("rst_r1", bus.Result1, 32'd0);
      chk("rst_r2", bus.Result2, 32'd0);
      chk("rst_r", bus.Result, 32'd0);
      chk("rst_done", {31'b0, bus.Done}, 32'd0);
      bus.Start = 1'b1;
      #1;
      chk("rst_busy", {31'b0, bus.Busy}, 32'd0);
      bus.Start = 1'b0;
      @(negedge CLK);
      RESETn = 1'b1;
      @(negedge CLK);

      foreach (tbl[i]) begin
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].nm, r1, r2, r, lat);
         chk({tbl[i].nm, ":r1"}, r1, tbl[i].r1);
         chk({tbl[i].nm, ":r2"}, r2, tbl[i].r2);
         chk({tbl[i].nm, ":r"}, r, tbl[i].r);
         chk({tbl[i].nm, ":lat"}, 32'(lat), 32'(tbl[i].lat));
      end

      // Abort in the second COMPUTE cycle.
      run_op(3'd7, 32'd100, 32'd7, "abort_pre", p1, p2, r, lat);
      bus.MCycleOp = 3'd4;
      bus.Operand1 = 32'd1000;
      bus.Operand2 = 32'd3;
      bus.Start    = 1'b1;
      @(posedge CLK);
      #1 bus.Start = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      bus.Abort = 1'b1;
      #1;
      chk("abort_busy", {31'b0, bus.Busy}, 32'd0);
      @(negedge CLK);
      bus.Abort = 1'b0;
      chk("abort_r1_hold", bus.Result1, p1);
      chk("abort_r2_hold", bus.Result2, p2);
      chk("abort_done", {31'b0, bus.Done}, 32'd0);
      run_op(3'd4, 32'd1000, 32'd3, "after_abort", r1, r2, r, lat);
      chk("after_abort:q", r1, 32'd333);
      chk("after_abort:r", r2, 32'd1);
      chk("after_abort:lat", 32'(lat), 32'd6);

      // Start held through DONE must not launch a second op.
      bus.MCycleOp = 3'd0;
      bus.Operand1 = 32'd7;
      bus.Operand2 = 32'hFFFF_FFFD;
      bus.Start    = 1'b1;
      lat = -1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge CLK);
         if (bus.Done) begin
            lat = c;
            break;
         end
      end
      bus.Start = 1'b0;
      chk("hold:lat", 32'(lat), 32'd6);
      chk("hold:r1", bus.Result1, 32'hFFFF_FFEB);
      for (int c = 0; c < 4; c++) begin
         @(negedge CLK);
         chk("hold:quiet", {30'b0, bus.Busy, bus.Done}, 32'd0);
      end

      // Asynchronous reset in the middle of a divide.
      bus.MCycleOp = 3'd5;
      bus.Operand1 = 32'd12345;
      bus.Operand2 = 32'd7;
      bus.Start    = 1'b1;
      @(posedge CLK);
      #1 bus.Start = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      #2 RESETn = 1'b0;
      #1;
      chk("midrst_r1", bus.Result1, 32'd0);
      chk("midrst_r2", bus.Result2, 32'd0);
      chk("midrst_r", bus.Result, 32'd0);
      chk("midrst_busy", {31'b0, bus.Busy}, 32'd0);
      @(negedge CLK);
      RESETn = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge CLK);
         chk("midrst_nodone", {31'b0, bus.Done}, 32'd0);
      end

      for (int n = 0; n < 150; n++) begin
         op = 3'($urandom);
         a  = pick();
         b  = pick();
         model(op, a, b, e1, e2, er, elat);
         run_op(op, a, b, "rnd", r1, r2, r, lat);
         chk("rnd:r1", r1, e1);
         chk("rnd:r2", r2, e2);
         chk("rnd:r", r, er);
         chk("rnd:lat", 32'(lat), 32'(elat));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
